// File: rtl/baccarat_fsm_if.sv
// Signal bundle between the baccarat round controller and its card/score datapath.
// The slave side is the controller; the master side drives step, scores and the third player card.
interface baccarat_fsm_if #(
    parameter int CARD_W  = 4,
    parameter int SCORE_W = 4
);
    logic               step;
    logic [SCORE_W-1:0] pscore;
    logic [SCORE_W-1:0] dscore;
    logic [CARD_W-1:0]  pcard3;
    logic               load_pcard1;
    logic               load_pcard2;
    logic               load_pcard3;
    logic               load_dcard1;
    logic               load_dcard2;
    logic               load_dcard3;
    logic               player_win_light;
    logic               dealer_win_light;
    logic               done;

    modport master (
        output step, pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, done
    );

    modport slave (
        input  step, pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, done
    );
endinterface

// File: rtl/baccarat_fsm.sv
// One-round baccarat sequencer: deals four cards, applies natural, player and banker
// drawing rules, then parks in DONE showing the winner until reset.
module baccarat_fsm #(
    parameter int CARD_W  = 4,
    parameter int SCORE_W = 4,
    parameter int NATURAL = 8
) (
    input  logic             slow_clock,
    input  logic             resetb,
    baccarat_fsm_if.slave    bus
);

    typedef enum logic [3:0] {
        S_DP1  = 4'd0,
        S_DD1  = 4'd1,
        S_DP2  = 4'd2,
        S_DD2  = 4'd3,
        S_CHK  = 4'd4,
        S_DP3  = 4'd5,
        S_CHKB = 4'd6,
        S_DD3  = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t state_q;
    state_t state_d;

    logic load_pcard1_s;
    logic load_pcard2_s;
    logic load_pcard3_s;
    logic load_dcard1_s;
    logic load_dcard2_s;
    logic load_dcard3_s;
    logic player_win_s;
    logic dealer_win_s;
    logic done_s;

    // Banker tableau: face cards and tens count as zero for the player's third card.
    function automatic logic banker_draws(input logic [SCORE_W-1:0] ds,
                                          input logic [CARD_W-1:0]  c3);
        logic [CARD_W-1:0] v;
        logic              draw;
        v = (c3 > CARD_W'(9)) ? CARD_W'(0) : c3;
        case (ds)
            SCORE_W'(0), SCORE_W'(1), SCORE_W'(2): draw = 1'b1;
            SCORE_W'(3): draw = (v != CARD_W'(8));
            SCORE_W'(4): draw = (v >= CARD_W'(2)) && (v <= CARD_W'(7));
            SCORE_W'(5): draw = (v >= CARD_W'(4)) && (v <= CARD_W'(7));
            SCORE_W'(6): draw = (v >= CARD_W'(6)) && (v <= CARD_W'(7));
            default:     draw = 1'b0;
        endcase
        return draw;
    endfunction

    // State register; reset parks the round back at the first deal.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_DP1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; nothing moves unless step is high.
    always_comb begin
        state_d = state_q;
        if (bus.step) begin
            case (state_q)
                S_DP1:  state_d = S_DD1;
                S_DD1:  state_d = S_DP2;
                S_DP2:  state_d = S_DD2;
                S_DD2:  state_d = S_CHK;
                S_CHK: begin
                    if ((bus.pscore >= SCORE_W'(NATURAL)) || (bus.dscore >= SCORE_W'(NATURAL))) begin
                        state_d = S_DONE;
                    end else if (bus.pscore <= SCORE_W'(5)) begin
                        state_d = S_DP3;
                    end else if (bus.dscore <= SCORE_W'(5)) begin
                        state_d = S_DD3;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DP3:  state_d = S_CHKB;
                S_CHKB: state_d = banker_draws(bus.dscore, bus.pcard3) ? S_DD3 : S_DONE;
                S_DD3:  state_d = S_DONE;
                S_DONE: state_d = S_DONE;
                default: state_d = S_DP1;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Moore decode; gated by resetb so everything is quiet while reset is held.
    // Lights follow the live scores because the last card lands on the edge entering DONE.
    always_comb begin
        load_pcard1_s = 1'b0;
        load_pcard2_s = 1'b0;
        load_pcard3_s = 1'b0;
        load_dcard1_s = 1'b0;
        load_dcard2_s = 1'b0;
        load_dcard3_s = 1'b0;
        player_win_s  = 1'b0;
        dealer_win_s  = 1'b0;
        done_s        = 1'b0;
        if (resetb) begin
            case (state_q)
                S_DP1:  load_pcard1_s = 1'b1;
                S_DD1:  load_dcard1_s = 1'b1;
                S_DP2:  load_pcard2_s = 1'b1;
                S_DD2:  load_dcard2_s = 1'b1;
                S_DP3:  load_pcard3_s = 1'b1;
                S_DD3:  load_dcard3_s = 1'b1;
                S_DONE: begin
                    done_s       = 1'b1;
                    player_win_s = (bus.pscore >= bus.dscore);
                    dealer_win_s = (bus.dscore >= bus.pscore);
                end
                default: done_s = 1'b0;
            endcase
        end else begin
            done_s = 1'b0;
        end
    end

    assign bus.load_pcard1      = load_pcard1_s;
    assign bus.load_pcard2      = load_pcard2_s;
    assign bus.load_pcard3      = load_pcard3_s;
    assign bus.load_dcard1      = load_dcard1_s;
    assign bus.load_dcard2      = load_dcard2_s;
    assign bus.load_dcard3      = load_dcard3_s;
    assign bus.player_win_light = player_win_s;
    assign bus.dealer_win_light = dealer_win_s;
    assign bus.done             = done_s;

endmodule

// File: tb/tb_baccarat_fsm.sv
// Bench for baccarat_fsm: directed rule table, stall/reset sequences, and random
// rounds compared cycle by cycle against a deal-sequence model of the game rules.
module tb_baccarat_fsm;

    logic slow_clock;
    logic resetb;

    baccarat_fsm_if #(.CARD_W(4), .SCORE_W(4)) bus ();

    baccarat_fsm #(.CARD_W(4), .SCORE_W(4), .NATURAL(8)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    // Observation layout {p1, p2, p3, d1, d2, d3, done}
    localparam logic [6:0] E_P1   = 7'b1000000;
    localparam logic [6:0] E_P2   = 7'b0100000;
    localparam logic [6:0] E_P3   = 7'b0010000;
    localparam logic [6:0] E_D1   = 7'b0001000;
    localparam logic [6:0] E_D2   = 7'b0000100;
    localparam logic [6:0] E_D3   = 7'b0000010;
    localparam logic [6:0] E_DONE = 7'b0000001;
    localparam logic [6:0] E_IDLE = 7'b0000000;

    typedef struct {
        int p; int d; int c3;
        int n_p3; int n_d3; int edges; int pw; int dw;
    } vec_t;

    int tests;
    int failed;
    logic [6:0] exp_q[$];
    logic [9:0] draw_mask [8];

    function automatic logic [6:0] obs();
        return {bus.load_pcard1, bus.load_pcard2, bus.load_pcard3,
                bus.load_dcard1, bus.load_dcard2, bus.load_dcard3, bus.done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected sequence of per-cycle outputs for one round, straight from the game rules.
    function automatic void build_model(input int p, input int d, input int c3);
        int v;
        exp_q = '{E_P1, E_D1, E_P2, E_D2, E_IDLE};
        if (p >= 8 || d >= 8) begin
        end else if (p <= 5) begin
            exp_q.push_back(E_P3);
            exp_q.push_back(E_IDLE);
            v = (c3 >= 10) ? 0 : c3;
            if (draw_mask[d][v]) exp_q.push_back(E_D3);
        end else if (d <= 5) begin
            exp_q.push_back(E_D3);
        end
        exp_q.push_back(E_DONE);
    endfunction

    task automatic do_reset();
        @(negedge slow_clock);
        resetb   = 1'b0;
        bus.step = 1'b0;
        #1;
        chk("reset_outputs", {23'd0, obs(), bus.player_win_light, bus.dealer_win_light}, 32'd0);
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    task automatic play_round(input int p, input int d, input int c3, input int stall_pct,
                              output int n_p3, output int n_d3, output int edges,
                              output int pw, output int dw);
        int idx, done_cyc, ps, ds;
        logic s;
        logic [6:0] o;
        build_model(p, d, c3);
        n_p3 = 0; n_d3 = 0; edges = 0; pw = 0; dw = 0; idx = 0; done_cyc = 0;
        do_reset();
        for (int cyc = 0; cyc < 200 && done_cyc < 3; cyc++) begin
            if (exp_q[idx] == E_DONE && done_cyc > 0) begin
                ps = $urandom_range(9); ds = $urandom_range(9);
            end else if (idx >= 4) begin
                ps = p; ds = d;
            end else begin
                ps = $urandom_range(9); ds = $urandom_range(9);
            end
            bus.pscore = 4'(ps);
            bus.dscore = 4'(ds);
            bus.pcard3 = (idx >= 5) ? 4'(c3) : 4'($urandom_range(13));
            #1;
            o = obs();
            chk("strobes", {25'd0, o}, {25'd0, exp_q[idx]});
            if (exp_q[idx] == E_DONE) begin
                chk("lights_done", {30'd0, bus.player_win_light, bus.dealer_win_light},
                    {30'd0, ps >= ds, ds >= ps});
                if (done_cyc == 0) begin
                    pw = int'(bus.player_win_light);
                    dw = int'(bus.dealer_win_light);
                end
                done_cyc++;
            end else begin
                chk("lights_off", {30'd0, bus.player_win_light, bus.dealer_win_light}, 32'd0);
            end
            s = ($urandom_range(99) >= stall_pct);
            bus.step = s;
            if (s && o[4]) n_p3++;
            if (s && o[1]) n_d3++;
            @(negedge slow_clock);
            if (s && exp_q[idx] != E_DONE) begin
                idx++;
                edges++;
            end
        end
        chk("round_completed", done_cyc, 3);
    endtask

    task automatic step_and_check(input logic s, input string name, input logic [6:0] exp);
        bus.step = s;
        @(negedge slow_clock);
        #1;
        chk(name, {25'd0, obs()}, {25'd0, exp});
    endtask

    vec_t vecs [12];
    int np3, nd3, ne, pw, dw;

    initial begin
        tests = 0; failed = 0;
        resetb = 1'b0; bus.step = 1'b0;
        bus.pscore = 4'd0; bus.dscore = 4'd0; bus.pcard3 = 4'd0;
        draw_mask = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC, 10'h0F0, 10'h0C0, 10'h000};

        //        p  d  c3 np3 nd3 edges pw dw
        vecs[0]  = '{9, 3,  0, 0, 0, 5, 1, 0};  // natural, player wins
        vecs[1]  = '{7, 6,  0, 0, 0, 5, 1, 0};  // both stand
        vecs[2]  = '{4, 4, 12, 1, 0, 7, 1, 1};  // face card counts 0: banker 4 stands
        vecs[3]  = '{4, 4,  5, 1, 1, 8, 1, 1};
        vecs[4]  = '{2, 3,  8, 1, 0, 7, 0, 1};  // banker 3 stands on 8
        vecs[5]  = '{2, 3,  9, 1, 1, 8, 0, 1};
        vecs[6]  = '{5, 6,  7, 1, 1, 8, 0, 1};
        vecs[7]  = '{5, 5,  1, 1, 0, 7, 1, 1};  // tie
        vecs[8]  = '{6, 5,  0, 0, 1, 6, 1, 0};  // player stands, banker draws
        vecs[9]  = '{2, 8,  0, 0, 0, 5, 0, 1};  // banker natural
        vecs[10] = '{3, 7,  2, 1, 0, 7, 0, 1};  // banker 7 always stands
        vecs[11] = '{0, 0, 13, 1, 1, 8, 1, 1};

        foreach (vecs[i]) begin
            play_round(vecs[i].p, vecs[i].d, vecs[i].c3, 0, np3, nd3, ne, pw, dw);
            chk($sformatf("vec%0d_p3_loads", i), np3, vecs[i].n_p3);
            chk($sformatf("vec%0d_d3_loads", i), nd3, vecs[i].n_d3);
            chk($sformatf("vec%0d_edges", i), ne, vecs[i].edges);
            chk($sformatf("vec%0d_player_win", i), pw, vecs[i].pw);
            chk($sformatf("vec%0d_dealer_win", i), dw, vecs[i].dw);
        end

        // Stall three cycles in DD1: strobe and state hold.
        do_reset();
        #1;
        chk("stall_dp1", {25'd0, obs()}, {25'd0, E_P1});
        step_and_check(1'b1, "stall_dd1_enter", E_D1);
        for (int k = 0; k < 3; k++) step_and_check(1'b0, "stall_dd1_hold", E_D1);
        step_and_check(1'b1, "stall_dp2", E_P2);

        // Async reset in DP3 between edges, then a clean restart.
        bus.pscore = 4'd4; bus.dscore = 4'd4; bus.pcard3 = 4'd5;
        do_reset();
        step_and_check(1'b1, "rst_dd1", E_D1);
        step_and_check(1'b1, "rst_dp2", E_P2);
        step_and_check(1'b1, "rst_dd2", E_D2);
        step_and_check(1'b1, "rst_chk", E_IDLE);
        step_and_check(1'b1, "rst_dp3", E_P3);
        #2;
        resetb = 1'b0;
        #1;
        chk("rst_async_outputs", {23'd0, obs(), bus.player_win_light, bus.dealer_win_light}, 32'd0);
        resetb = 1'b1;
        #1;
        chk("rst_back_at_dp1", {25'd0, obs()}, {25'd0, E_P1});
        @(negedge slow_clock);
        #1;
        step_and_check(1'b1, "rst_restart_dd1", E_D1);

        // Random rounds with random stalls.
        for (int r = 0; r < 40; r++) begin
            play_round($urandom_range(9), $urandom_range(9), $urandom_range(13), 30,
                       np3, nd3, ne, pw, dw);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
